// File: rtl/mips_pkg.sv
// mips_pkg: shared states, instruction classes, opcode/function constants and decode helper
package mips_pkg;

   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

   typedef enum logic [2:0] {I_ADDU, I_ADDIU, I_LW, I_SW, I_JR, I_BAD} instr_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_JR   = 6'h08;

   localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [31:0] DEF_HALT_ADDR    = 32'h0000_0000;

   function automatic instr_t classify(input logic [5:0] op, input logic [5:0] fn);
      return (op == OP_RTYPE && fn == FN_ADDU) ? I_ADDU  :
             (op == OP_RTYPE && fn == FN_JR)   ? I_JR    :
             (op == OP_ADDIU)                  ? I_ADDIU :
             (op == OP_LW)                     ? I_LW    :
             (op == OP_SW)                     ? I_SW    : I_BAD;
   endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational map from (state, opcode, func) to memory and datapath strobes
module mips_ctrl_decode
   import mips_pkg::*;
(
   input  state_t      i_state,
   input  logic [5:0]  i_opcode,
   input  logic [5:0]  i_func,
   output logic        o_instr_read,
   output logic        o_data_read,
   output logic        o_data_write,
   output logic        o_reg_dst,
   output logic        o_mem_to_reg,
   output logic        o_alu_src,
   output logic        o_reg_write
);

   instr_t w_kind;

   assign w_kind = classify(i_opcode, i_func);

   assign o_instr_read = (i_state == S_FETCH);
   // LW keeps data_read up through WB so the returned word stays valid for the write-back
   assign o_data_read  = (i_state == S_MEM || i_state == S_WB) && w_kind == I_LW;
   assign o_data_write = (i_state == S_MEM) && w_kind == I_SW;
   assign o_reg_write  = (i_state == S_WB);
   assign o_reg_dst    = ((i_state == S_EXEC || i_state == S_WB) && w_kind == I_ADDIU) ||
                         (i_state == S_WB && w_kind == I_LW);
   assign o_mem_to_reg = (i_state == S_WB) && w_kind == I_LW;
   // Immediate operand stays selected from EXEC through MEM and WB
   assign o_alu_src    = (i_state inside {S_EXEC, S_MEM, S_WB}) &&
                         (w_kind inside {I_ADDIU, I_LW, I_SW});

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multi-cycle sequencer and PC owner for the ADDU/ADDIU/LW/SW/JR datapath
// Optional cycle/instruction counters are enabled by defining MIPS_CTRL_PERF_EN.
module mips_mc_control
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
   parameter logic [31:0] HALT_ADDR    = DEF_HALT_ADDR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_readdata,
   input  logic        instr_waitrequest,
   input  logic        data_waitrequest,
   input  logic [31:0] rs_data,
   output logic [31:0] instr_address,
   output logic        instr_read,
   output logic        data_read,
   output logic        data_write,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [5:0]  func_code,
   output logic [5:0]  ALUOp,
   output logic [15:0] alu_immediate,
   output logic        RegDst,
   output logic        MemtoReg,
   output logic        ALUSrc,
   output logic        RegWrite,
   output logic        active,
   output logic        illegal
`ifdef MIPS_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instr_count
`endif
);

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic        r_illegal;
   instr_t      w_kind;
   logic        w_instr_read;
   logic        w_data_read;
   logic        w_data_write;
   logic        w_reg_dst;
   logic        w_mem_to_reg;
   logic        w_alu_src;
   logic        w_reg_write;

   assign w_kind = classify(r_ir[31:26], r_ir[5:0]);

   mips_ctrl_decode u_decode (
      .i_state      (r_state),
      .i_opcode     (r_ir[31:26]),
      .i_func       (r_ir[5:0]),
      .o_instr_read (w_instr_read),
      .o_data_read  (w_data_read),
      .o_data_write (w_data_write),
      .o_reg_dst    (w_reg_dst),
      .o_mem_to_reg (w_mem_to_reg),
      .o_alu_src    (w_alu_src),
      .o_reg_write  (w_reg_write)
   );

   // Strobes are forced low while reset is held so nothing is requested mid-reset
   assign instr_read    = w_instr_read & ~reset;
   assign data_read     = w_data_read  & ~reset;
   assign data_write    = w_data_write & ~reset;
   assign RegDst        = w_reg_dst    & ~reset;
   assign MemtoReg      = w_mem_to_reg & ~reset;
   assign ALUSrc        = w_alu_src    & ~reset;
   assign RegWrite      = w_reg_write  & ~reset;
   assign instr_address = r_pc;
   assign rs            = r_ir[25:21];
   assign rt            = r_ir[20:16];
   assign rd            = r_ir[15:11];
   assign func_code     = r_ir[5:0];
   assign ALUOp         = r_ir[31:26];
   assign alu_immediate = r_ir[15:0];
   assign active        = (r_state != S_HALT);
   assign illegal       = r_illegal;

   // Instruction sequencing: state, PC, latched IR and sticky illegal flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_pc      <= RESET_VECTOR;
         r_ir      <= 32'h0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (!instr_waitrequest) begin
                  r_ir    <= instr_readdata;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= (w_kind == I_BAD) ? S_HALT : S_EXEC;
               if (w_kind == I_BAD) r_illegal <= 1'b1;
            end
            S_EXEC: begin
               if (w_kind == I_JR) begin
                  if (rs_data == HALT_ADDR) r_state <= S_HALT;
                  else begin
                     r_pc    <= rs_data;
                     r_state <= S_FETCH;
                  end
               end else r_state <= (w_kind == I_LW || w_kind == I_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
               if (!data_waitrequest) begin
                  if (w_kind == I_SW) begin
                     r_pc    <= r_pc + 32'd4;
                     r_state <= S_FETCH;
                  end else r_state <= S_WB;
               end
            end
            S_WB: begin
               r_pc    <= r_pc + 32'd4;
               r_state <= S_FETCH;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

`ifdef MIPS_CTRL_PERF_EN
   logic [31:0] r_cycle_count;
   logic [31:0] r_instr_count;
   logic        w_retire;

   assign w_retire = (r_state == S_WB) ||
                     (r_state == S_MEM && w_kind == I_SW && !data_waitrequest) ||
                     (r_state == S_EXEC && w_kind == I_JR && rs_data != HALT_ADDR);
   assign cycle_count = r_cycle_count;
   assign instr_count = r_instr_count;

   // Performance counters; both stop once the core halts
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle_count <= 32'h0;
         r_instr_count <= 32'h0;
      end else begin
         if (r_state != S_HALT) r_cycle_count <= r_cycle_count + 32'd1;
         if (w_retire) r_instr_count <= r_instr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control: randomized script-driven bench with a per-instruction cycle model
module tb_mips_mc_control;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] instr_readdata = 32'h0;
   logic        instr_waitrequest = 1'b0;
   logic        data_waitrequest = 1'b0;
   logic [31:0] rs_data = 32'h0;
   logic [31:0] instr_address;
   logic        instr_read, data_read, data_write;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  func_code, ALUOp;
   logic [15:0] alu_immediate;
   logic        RegDst, MemtoReg, ALUSrc, RegWrite, active, illegal;
`ifdef MIPS_CTRL_PERF_EN
   logic [31:0] cycle_count, instr_count;
`endif

   mips_mc_control dut (
      .clk               (clk),
      .reset             (reset),
      .instr_readdata    (instr_readdata),
      .instr_waitrequest (instr_waitrequest),
      .data_waitrequest  (data_waitrequest),
      .rs_data           (rs_data),
      .instr_address     (instr_address),
      .instr_read        (instr_read),
      .data_read         (data_read),
      .data_write        (data_write),
      .rs                (rs),
      .rt                (rt),
      .rd                (rd),
      .func_code         (func_code),
      .ALUOp             (ALUOp),
      .alu_immediate     (alu_immediate),
      .RegDst            (RegDst),
      .MemtoReg          (MemtoReg),
      .ALUSrc            (ALUSrc),
      .RegWrite          (RegWrite),
      .active            (active),
      .illegal           (illegal)
`ifdef MIPS_CTRL_PERF_EN
      ,
      .cycle_count       (cycle_count),
      .instr_count       (instr_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iw, dw;
      logic [31:0] rdata, rsd, addr, word;
      logic        ir, dr, dwr, rdst, m2r, asrc, rw, act, ill, chk_ir, retire;
   } cyc_t;

   cyc_t        q[$];
   logic [31:0] m_pc;
   logic        m_ill, m_halt;
   int          m_cyc, m_ins;
   int          checks, errors;
   int          n_dwr, n_ir;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
      end
   endtask

   // 0 ADDU, 1 ADDIU, 2 LW, 3 SW, 4 JR, 5 unsupported
   function automatic int kind_of(input logic [31:0] w);
      case (w[31:26])
         6'h00:   return (w[5:0] == 6'h21) ? 0 : (w[5:0] == 6'h08) ? 4 : 5;
         6'h09:   return 1;
         6'h23:   return 2;
         6'h2B:   return 3;
         default: return 5;
      endcase
   endfunction

   function automatic cyc_t blank();
      cyc_t e;
      e.iw = 1'($urandom()); e.dw = 1'($urandom());
      e.rdata = $urandom(); e.rsd = $urandom(); e.addr = m_pc; e.word = 32'h0;
      e.ir = 0; e.dr = 0; e.dwr = 0; e.rdst = 0; e.m2r = 0; e.asrc = 0; e.rw = 0;
      e.act = !m_halt; e.ill = m_ill; e.chk_ir = 0; e.retire = 0;
      return e;
   endfunction

   function automatic cyc_t stage(input logic [31:0] w);
      cyc_t e;
      e = blank(); e.chk_ir = 1'b1; e.word = w;
      return e;
   endfunction

   // Append the expected cycle-by-cycle behaviour of one instruction
   task automatic add_instr(input logic [31:0] w, input int fw, input int dwn, input logic [31:0] tgt);
      cyc_t e;
      int   k;
      k = kind_of(w);
      for (int i = 0; i <= fw; i++) begin
         e = blank(); e.ir = 1'b1; e.iw = (i < fw); e.rdata = (i == fw) ? w : $urandom();
         q.push_back(e);
      end
      e = stage(w); q.push_back(e);
      if (k == 5) begin
         m_ill = 1'b1; m_halt = 1'b1;
         return;
      end
      e = stage(w);
      e.asrc = (k == 1 || k == 2 || k == 3); e.rdst = (k == 1);
      if (k == 4) begin
         e.rsd = tgt; e.retire = (tgt != 32'h0); q.push_back(e);
         if (tgt == 32'h0) m_halt = 1'b1; else m_pc = tgt;
         return;
      end
      q.push_back(e);
      if (k == 2 || k == 3)
         for (int i = 0; i <= dwn; i++) begin
            e = stage(w); e.asrc = 1'b1; e.dw = (i < dwn);
            e.dr = (k == 2); e.dwr = (k == 3); e.retire = (k == 3 && i == dwn);
            q.push_back(e);
         end
      if (k != 3) begin
         e = stage(w); e.rw = 1'b1; e.rdst = (k != 0); e.m2r = (k == 2);
         e.asrc = (k != 0); e.dr = (k == 2); e.retire = 1'b1;
         q.push_back(e);
      end
      m_pc = m_pc + 32'd4;
   endtask

   task automatic add_idle(input int n);
      for (int i = 0; i < n; i++) q.push_back(blank());
   endtask

   // Single compare point for every scripted cycle
   task automatic check(input cyc_t e);
      chk("pc", 64'(instr_address), 64'(e.addr));
      chk("strobes", 64'({instr_read, data_read, data_write, RegDst, MemtoReg, ALUSrc, RegWrite, active, illegal}),
          64'({e.ir, e.dr, e.dwr, e.rdst, e.m2r, e.asrc, e.rw, e.act, e.ill}));
      if (e.chk_ir)
         chk("fields", 64'({ALUOp, rs, rt, rd, func_code, alu_immediate}),
             64'({e.word[31:26], e.word[25:21], e.word[20:16], e.word[15:11], e.word[5:0], e.word[15:0]}));
`ifdef MIPS_CTRL_PERF_EN
      chk("cycle_count", 64'(cycle_count), 64'(m_cyc));
      chk("instr_count", 64'(instr_count), 64'(m_ins));
`endif
      if (e.act) m_cyc++;
      if (e.retire) m_ins++;
      if (data_write) n_dwr++;
      if (instr_read) n_ir++;
   endtask

   task automatic run_script(input int n);
      cyc_t e;
      int   k;
      k = 0;
      while (q.size() > 0 && (n < 0 || k < n)) begin
         e = q.pop_front();
         instr_waitrequest = e.iw; data_waitrequest = e.dw;
         instr_readdata = e.rdata; rs_data = e.rsd;
         #2;
         check(e);
         @(negedge clk);
         k++;
      end
      q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_strobes_async", 64'({instr_read, data_read, data_write, RegWrite, RegDst, MemtoReg, ALUSrc}), 64'd0);
      @(posedge clk);
      #1;
      chk("rst_strobes", 64'({instr_read, data_read, data_write, RegWrite, RegDst, MemtoReg, ALUSrc}), 64'd0);
      chk("rst_flags", 64'({active, illegal}), 64'b10);
      @(negedge clk);
      chk("rst_pc", 64'(instr_address), 64'(RV));
      reset = 1'b0;
      m_pc = RV; m_ill = 1'b0; m_halt = 1'b0; m_cyc = 0; m_ins = 0;
      q.delete();
   endtask

   function automatic logic [31:0] rand_word(input int k);
      logic [31:0] r;
      logic [5:0]  op;
      r = $urandom();
      case (k)
         0: return {6'h00, r[25:6], 6'h21};
         1: return {6'h09, r[25:0]};
         2: return {6'h23, r[25:0]};
         3: return {6'h2B, r[25:0]};
         4: return {6'h00, r[25:21], 15'h0, 6'h08};
         default: begin
            op = r[31:26];
            if (op inside {6'h00, 6'h09, 6'h23, 6'h2B}) op = 6'h3F;
            return r[0] ? {6'h00, r[25:6], 6'h20} : {op, r[25:0]};
         end
      endcase
   endfunction

   task automatic gen_program(input int n);
      int          k;
      logic [31:0] tgt;
      if ($urandom_range(0, 3) == 0) add_instr(rand_word(4), 0, 0, 32'hFFFF_FFFC);
      for (int i = 0; i < n && !m_halt; i++) begin
         k = $urandom_range(0, 20);
         k = (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : (k < 16) ? 3 : (k < 19) ? 4 : 5;
         tgt = ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom();
         add_instr(rand_word(k), $urandom_range(0, 3), $urandom_range(0, 3), tgt);
      end
      if (!m_halt) add_instr(rand_word(4), 0, 0, 32'h0);
      add_idle(3);
   endtask

   initial begin
      int d0;
      checks = 0; errors = 0; n_dwr = 0; n_ir = 0;
      m_pc = RV; m_ill = 0; m_halt = 0; m_cyc = 0; m_ins = 0;
      @(negedge clk);
      do_reset();
      // ADDIU $2,$0,5 then ADDU $3,$2,$2 with no wait states
      add_instr(32'h2402_0005, 0, 0, 0);
      add_instr(32'h0042_1821, 0, 0, 0);
      run_script(-1);
      chk("pc_after_8", 64'(instr_address), 64'h0000_0000_BFC0_0008);
      // SW with three data wait cycles
      d0 = n_dwr;
      add_instr(32'hAC43_0004, 0, 3, 0);
      run_script(-1);
      chk("sw_write_cycles", 64'(n_dwr - d0), 64'd4);
      chk("pc_after_sw", 64'(instr_address), 64'h0000_0000_BFC0_000C);
      // LW with two instruction wait cycles
      d0 = n_ir;
      add_instr(32'h8C44_0004, 2, 0, 0);
      run_script(-1);
      chk("lw_fetch_cycles", 64'(n_ir - d0), 64'd3);
      chk("pc_after_lw", 64'(instr_address), 64'h0000_0000_BFC0_0010);
      // JR to 0x1000, then JR to the top of the address space and wrap
      add_instr(32'h03E0_0008, 0, 0, 32'h0000_1000);
      run_script(-1);
      chk("pc_after_jr", 64'(instr_address), 64'h0000_0000_0000_1000);
      add_instr(32'h03E0_0008, 0, 0, 32'hFFFF_FFFC);
      add_instr(32'h0042_1821, 0, 0, 0);
      run_script(-1);
      chk("pc_wrap", 64'(instr_address), 64'h0);
      // JR to the halt address
      add_instr(32'h03E0_0008, 0, 0, 32'h0);
      add_idle(5);
      run_script(-1);
      chk("halt_active", 64'({active, illegal}), 64'b00);
`ifdef MIPS_CTRL_PERF_EN
      chk("perf_instr_lit", 64'(instr_count), 64'd7);
      chk("perf_cycle_lit", 64'(cycle_count), 64'd35);
`endif
      // Reset in the middle of a stalled LW memory phase
      do_reset();
      add_instr(32'h8C44_0004, 0, 6, 0);
      run_script(5);
      #2;
      do_reset();
      add_instr(32'h0042_1821, 0, 0, 0);
      run_script(-1);
      chk("pc_after_rst_addu", 64'(instr_address), 64'h0000_0000_BFC0_0004);
      // Unsupported opcode halts and sets the sticky flag
      do_reset();
      add_instr(32'hFC00_0000, 0, 0, 0);
      add_idle(4);
      run_script(-1);
      chk("illegal_halt", 64'({active, illegal}), 64'b01);
      // Randomized programs
      for (int p = 0; p < 40; p++) begin
         do_reset();
         gen_program($urandom_range(1, 15));
         run_script(-1);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
